// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the parametrised dav_/rfd pulse generator.
//   - command encodings carried on modo
//   - FSM state encoding
//   - phase length helper: SCALE*(numero+1)-1, computed in 32-bit unsigned
//     so the top code (numero = 2^W-1) cannot wrap before truncation to CW.
package pulse_gen_pkg;

  localparam logic [1:0] MODO_SINGLE   = 2'b00;
  localparam logic [1:0] MODO_PERIODIC = 2'b01;
  localparam logic [1:0] MODO_STOP     = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  // Counter reload value for a phase of SCALE*(num+1) cycles.
  function automatic int unsigned phase_len_m1(int unsigned scale, int unsigned num);
    return scale * (num + 1) - 1;
  endfunction

endpackage

// File: rtl/pulse_gen_param_if.sv
// Producer-side bus of the pulse generator.
//   numero [W-1:0] duration code, sampled on acceptance
//   modo   [1:0]   command (single / periodic / stop / reserved)
//   dav_           data valid, active low
//   rfd            ready for data, active high
//   out            generated waveform
// master: producer / testbench.  slave: pulse_gen_param.
interface pulse_gen_param_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] numero;
  logic [1:0]   modo;
  logic         dav_;
  logic         rfd;
  logic         out;

  modport master (output numero, modo, dav_, input rfd, out);
  modport slave  (input numero, modo, dav_, output rfd, out);
endinterface

// File: rtl/phase_counter.sv
// Loadable CW-bit down-counter used to time each high/low phase.
//   clock, reset_  system clock, async active-low reset (count -> 0)
//   load           load load_value this edge (wins over enable)
//   load_value     reload value (phase length minus one)
//   en             decrement this edge; holds at zero
//   zero           count == 0, i.e. this edge ends the current phase
module phase_counter #(
  parameter int unsigned CW = 5
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          en,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_gen_param.sv
// Parametrised pulse generator behind a dav_/rfd handshake.
// An accepted single-shot or periodic command drives out high for
// L = SCALE*(numero+1) cycles starting on the acceptance edge; periodic
// repeats L high / L low until another command arrives. Stop (or the
// reserved code) forces out low and returns to IDLE.
//   clock, reset_  system clock, async active-low reset
//   bus            slave side of pulse_gen_param_if (numero, modo, dav_
//                  in; rfd, out out)
// rfd is its own register: it drops on acceptance and comes back on the
// first edge with dav_ high while idle or running periodic, so a dav_
// held low across the return can never be taken as a second command.
module pulse_gen_param
  import pulse_gen_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned SCALE = 2
) (
  input  logic                 clock,
  input  logic                 reset_,
  pulse_gen_param_if.slave     bus
);

  localparam int unsigned CW = $clog2(SCALE * (2 ** W));

  state_e        state_q, state_d;
  logic          out_q, out_d;
  logic          rfd_q, rfd_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  num_q, num_d;

  logic          accept;
  logic          cnt_load, cnt_en, cnt_zero;
  logic [CW-1:0] cnt_load_value;

  assign accept = rfd_q && !bus.dav_;

  phase_counter #(.CW(CW)) u_phase (
    .clock      (clock),
    .reset_     (reset_),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .en         (cnt_en),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      out_q   <= 1'b0;
      rfd_q   <= 1'b1;
      mode_q  <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rfd_q   <= rfd_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    out_d          = out_q;
    rfd_d          = rfd_q;
    mode_d         = mode_q;
    num_d          = num_q;
    cnt_load       = 1'b0;
    cnt_en         = 1'b0;
    // Periodic reloads reuse the latched code.
    cnt_load_value = CW'(phase_len_m1(SCALE, 32'(num_q)));

    if (accept) begin
      // A new command aborts whatever phase is running.
      rfd_d  = 1'b0;
      mode_d = bus.modo;
      num_d  = bus.numero;
      if ((bus.modo == MODO_SINGLE) || (bus.modo == MODO_PERIODIC)) begin
        state_d        = S_HIGH;
        out_d          = 1'b1;
        cnt_load       = 1'b1;
        cnt_load_value = CW'(phase_len_m1(SCALE, 32'(bus.numero)));
      end else begin
        state_d = S_IDLE;
        out_d   = 1'b0;
      end
    end else begin
      case (state_q)
        S_HIGH: begin
          if (cnt_zero) begin
            out_d = 1'b0;
            if (mode_q == MODO_PERIODIC) begin
              state_d  = S_LOW;
              cnt_load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        S_LOW: begin
          if (cnt_zero) begin
            out_d    = 1'b1;
            state_d  = S_HIGH;
            cnt_load = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        S_IDLE: ;
        default: begin
          state_d = S_IDLE;
          out_d   = 1'b0;
        end
      endcase

      // Single-shot keeps rfd low until the pulse is over.
      if (!rfd_q && bus.dav_ && ((state_q == S_IDLE) || (mode_q == MODO_PERIODIC)))
        rfd_d = 1'b1;
    end
  end

  assign bus.out = out_q;
  assign bus.rfd = rfd_q;

endmodule

// File: doc/pulse_gen_param.md
Name: pulse_gen_param

Overview:
Parametrised successor of the dav_/rfd pulse generator. Accepts a duration code and a mode word through the dav_/rfd handshake. Drives out high for SCALE*(numero+1) clock cycles, either once (single-shot) or as a repeating square wave (periodic). A stop command ends a periodic train. The block sits behind a producer that uses the standard active-low dav_ / active-high rfd handshake.

Parameters:
W, 4, width of numero (duration code, 0..2^W-1)
SCALE, 2, clock cycles per duration unit (>=1)
CW, $clog2(SCALE*2**W), phase counter width (derived, localparam)

Ports:
clock  in  1  system clock, all state changes on posedge
reset_  in  1  asynchronous, active-low reset
numero  in  W  duration code, sampled on acceptance
modo  in  2  command: 00 single-shot, 01 periodic, 10 stop, 11 reserved (treated as stop)
dav_  in  1  data valid, active low
rfd  out  1  ready for data, active high
out  out  1  generated waveform

Behaviour:
- Reset (asynchronous, reset_=0): out=0, rfd=1, state IDLE, counter=0, latched registers=0. Asserting reset mid-pulse ends the pulse immediately.
- Acceptance: at a posedge where rfd==1 and dav_==0, latch numero and modo and clear rfd to 0 on that edge.
- rfd returns to 1 at the first posedge where dav_==1 and one of these holds: the generator is in IDLE, or the latched mode is periodic.
- In single-shot mode rfd stays 0 until the pulse has finished, even if dav_ has already risen.
- Length L = SCALE*(numero+1) cycles. The arithmetic is unsigned in CW bits, so numero = 2^W-1 must not overflow.
- On acceptance of single-shot or periodic: out goes 1 on the acceptance edge, so out rises in the same cycle rfd falls. Counter loads L-1. State becomes HIGH.
- HIGH: out=1. Counter decrements each edge. On the edge where counter==0:
  - Single-shot: out goes 0 and state becomes IDLE.
  - Periodic: out goes 0, counter reloads L-1, state becomes LOW.
  - The high time is exactly L cycles.
- LOW (periodic only): out=0. Counter decrements. At 0, out goes 1, counter reloads L-1, state becomes HIGH. The period is 2L and the duty cycle is 50%.
- New command during periodic operation (rfd==1 and dav_==0 in HIGH or LOW):
  - The current phase is aborted on that edge.
  - Single-shot or periodic: reload with the new L, out goes 1 (a fresh high phase starts).
  - Stop: out goes 0 and state becomes IDLE.
- Stop or reserved accepted in IDLE: no pulse, out stays 0. rfd returns on dav_==1.
- dav_ held low across the rfd rise is not a new command. A second acceptance requires dav_ to have been seen high after rfd fell, which the rfd return rule guarantees.
- numero and modo need only be stable in the cycle in which acceptance happens.
- States: IDLE, HIGH, LOW. Acceptance readiness is held in a separate rfd register, not in the state.

Decomposition:
- Shared package pulse_gen_pkg holds:
  - command encodings MODO_SINGLE=2'b00, MODO_PERIODIC=2'b01, MODO_STOP=2'b10;
  - state encodings S_IDLE, S_HIGH, S_LOW.
- One sub-module, phase_counter: a CW-bit loadable down-counter with load, load_value, enable, and a zero flag. Parametrised by CW, with asynchronous active-low reset.
- The top level holds the FSM and the handshake logic.

Test Plan (W=4, SCALE=2, clock period 10):
1. Reset -> out=0, rfd=1 at the first negedge after reset_ rises. Pulse reset_ low mid-HIGH -> out=0 and rfd=1 immediately.
2. Single-shot, numero 0,1,2,3 in sequence, each through a full handshake -> out high for exactly 2,4,6,8 cycles. rfd rises only after out falls and dav_=1.
3. Single-shot with numero=15 -> out high for 32 cycles, no counter overflow. Holding dav_ low throughout -> rfd stays 0 and there is no second pulse.
4. Periodic, numero=2 -> out high 6 cycles, low 6 cycles, repeating for at least 3 periods. rfd returns to 1 one cycle after dav_ goes to 1, while the train continues.
5. Periodic numero=2 running, then in the LOW phase accept periodic numero=0 -> out rises on the acceptance edge, and from then on high 2 / low 2. Then accept stop -> out=0 on the acceptance edge and stays 0, state IDLE.
6. Stop, and reserved modo=11, accepted in IDLE -> out stays 0, and the rfd handshake completes normally (rfd falls, then rises after dav_=1).
